wb_mem: RTL and testbench

Pipelined Wishbone B4 slave memory: the responder end of the instruction-fetch bus. It accepts one read or write request per cycle from a Wishbone master (the FETCH stage or a data port), and returns each acknowledge a fixed, parameterised latency later. After reset it self-initialises every word to the bitwise inverse of its address while stalling the bus. Fetch and system benches therefore get a known, checkable memory image without an init file.

---
 rtl/wb_mem_pkg.sv | 18 +
 rtl/wb_mem_ram.sv | 34 +++
 rtl/wb_mem.sv | 131 +++++++++++++
 tb/tb_wb_mem.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_pkg.sv
// Shared state type, limits and power-up image rule for the wb_mem Wishbone slave.
package wb_mem_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam int MAX_LATENCY   = 4;
  localparam int MAX_DATA_BITS = 32;

  // Power-up image: each word holds the bitwise inverse of its own address.
  // Callers truncate the 32-bit result to their data width.
  function automatic logic [MAX_DATA_BITS-1:0] clear_value(input logic [MAX_DATA_BITS-1:0] addr);
    return ~addr;
  endfunction

endpackage

// File: rtl/wb_mem_ram.sv
// Single-port synchronous RAM with a read-before-write output register.
module wb_mem_ram
  import wb_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_reg [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_reg[addr] <= wr_data;
    end
  end

  // Non-blocking read of the same address returns the word before this edge's write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_reg[addr];
    end
  end

endmodule

// File: rtl/wb_mem.sv
// Pipelined Wishbone B4 slave memory: self-clearing after reset, fixed-latency acks.
module wb_mem
  import wb_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LATENCY   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic                 wb_stall_o,
  input  logic [15:0]          wb_addr_i,
  input  logic                 wb_we_i,
  input  logic [DATA_BITS-1:0] wb_dat_i,
  output logic                 wb_ack_o,
  output logic [DATA_BITS-1:0] wb_data_o
);

  generate
    if (LATENCY < 1 || LATENCY > MAX_LATENCY || DATA_BITS > MAX_DATA_BITS ||
        ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_params
      $error("wb_mem: LATENCY must be 1..4, DATA_BITS <= 32, ADDR_BITS 1..16");
    end
  endgenerate

  state_e               state_reg, state_next;
  logic [ADDR_BITS-1:0] clr_addr_reg, clr_addr_next;
  logic                 accept;
  logic                 ram_wr_en;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_BITS-1:0] ram_wr_data;
  logic [DATA_BITS-1:0] ram_rd_data;
  logic [LATENCY-1:0]   valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // The clear walk owns the RAM port until the last word is written.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    wb_stall_o    = 1'b1;
    accept        = 1'b0;
    ram_wr_en     = 1'b0;
    ram_addr      = wb_addr_i[ADDR_BITS-1:0];
    ram_wr_data   = wb_dat_i;
    case (state_reg)
      CLEAR: begin
        ram_wr_en     = 1'b1;
        ram_addr      = clr_addr_reg;
        ram_wr_data   = DATA_BITS'(clear_value(MAX_DATA_BITS'(clr_addr_reg)));
        clr_addr_next = clr_addr_reg + 1'b1;
        if (&clr_addr_reg) begin
          state_next = READY;
        end
      end
      READY: begin
        wb_stall_o = 1'b0;
        accept     = wb_cyc_i && wb_stb_i;
        ram_wr_en  = accept && wb_we_i;
      end
    endcase
  end

  wb_mem_ram #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rd_en  (accept),
    .wr_en  (ram_wr_en),
    .addr   (ram_addr),
    .wr_data(ram_wr_data),
    .rd_data(ram_rd_data)
  );

  // Dropping the cycle flushes every outstanding response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= '0;
    end else if (!wb_cyc_i) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
      end
    end
  end

  assign wb_ack_o = valid_reg[LATENCY-1] && wb_cyc_i;

  generate
    if (LATENCY == 1) begin : g_no_delay
      assign wb_data_o = ram_rd_data;
    end else begin : g_delay
      logic [DATA_BITS-1:0] data_reg [LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            data_reg[i] <= '0;
          end
        end else begin
          data_reg[0] <= ram_rd_data;
          for (int i = 1; i < LATENCY - 1; i++) begin
            data_reg[i] <= data_reg[i-1];
          end
        end
      end

      assign wb_data_o = data_reg[LATENCY-2];
    end

    if (ADDR_BITS < 16) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^wb_addr_i[15:ADDR_BITS];
    end
  endgenerate

endmodule

// File: tb/tb_wb_mem.sv
// Randomised bench for wb_mem against a queue-based response model of the memory.
module tb_wb_mem;

  localparam int AB    = 8;
  localparam int DB    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AB;

  logic          clk_i     = 1'b0;
  logic          rst_i     = 1'b1;
  logic          wb_cyc_i  = 1'b0;
  logic          wb_stb_i  = 1'b0;
  logic          wb_we_i   = 1'b0;
  logic [15:0]   wb_addr_i = '0;
  logic [DB-1:0] wb_dat_i  = '0;
  logic          wb_stall_o;
  logic          wb_ack_o;
  logic [DB-1:0] wb_data_o;

  always #5 clk_i = ~clk_i;

  wb_mem #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .LATENCY  (LAT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_stall_o(wb_stall_o),
    .wb_addr_i (wb_addr_i),
    .wb_we_i   (wb_we_i),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_o  (wb_ack_o),
    .wb_data_o (wb_data_o)
  );

  // Expected response: the edge after which the ack is visible, and its data.
  typedef struct {
    int            due;
    logic [DB-1:0] data;
  } resp_t;

  resp_t         pending[$];
  logic [DB-1:0] ref_mem [DEPTH];
  int            edge_n;
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = DB'(~i);
    end
    pending.delete();
    edge_n = 0;
  endtask

  // Compare outputs for the cycle after edge edge_n, with the inputs now applied.
  task automatic check_outputs();
    logic          exp_ack;
    logic [DB-1:0] exp_data;
    exp_ack  = 1'b0;
    exp_data = '0;
    foreach (pending[i]) begin
      if (pending[i].due == edge_n) begin
        exp_ack  = wb_cyc_i;
        exp_data = pending[i].data;
      end
    end
    check_eq("stall", 32'(wb_stall_o), 32'(edge_n < DEPTH));
    check_eq("ack", 32'(wb_ack_o), 32'(exp_ack));
    if (exp_ack) begin
      check_eq("rdata", 32'(wb_data_o), 32'(exp_data));
      $display("txn: ack after edge %0d data 0x%04h expected 0x%04h", edge_n, wb_data_o, exp_data);
    end
  endtask

  // Effect of one rising edge on the reference model.
  task automatic model_edge();
    resp_t r;
    int    a;
    if (!wb_cyc_i) begin
      pending.delete();
    end else if (edge_n >= DEPTH && wb_stb_i) begin
      a      = int'(wb_addr_i) % DEPTH;
      r.due  = edge_n + LAT;
      r.data = ref_mem[a];
      pending.push_back(r);
      if (wb_we_i) ref_mem[a] = wb_dat_i;
    end
    edge_n++;
    while (pending.size() > 0 && pending[0].due < edge_n) begin
      void'(pending.pop_front());
    end
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [15:0] addr, input logic [DB-1:0] dat);
    wb_cyc_i  = cyc;
    wb_stb_i  = stb;
    wb_we_i   = we;
    wb_addr_i = addr;
    wb_dat_i  = dat;
    #1;
    check_outputs();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 16'h0000, '0);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    #1;
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_stall", 32'(wb_stall_o), 32'd1);
    check_eq("rst_data", 32'(wb_data_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic random_clear_phase();
    repeat (DEPTH) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 16'($urandom), DB'($urandom));
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    pulse_reset();
    random_clear_phase();

    drive(1'b1, 1'b1, 1'b0, 16'h0005, '0);
    idle(LAT + 1);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 16'(16'h0010 + i), '0);
    idle(LAT + 1);

    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0120, '0);
    idle(LAT + 1);

    drive(1'b1, 1'b1, 1'b0, 16'h0030, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0031, '0);
    repeat (LAT + 1) drive(1'b0, 1'b0, 1'b0, 16'h0000, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0003, '0);
    idle(LAT + 1);

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 16'(16'h0040 + i), '0);
    idle(LAT + 1);

    repeat (600) begin
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) < 3), 16'($urandom) & 16'hFF1F, DB'($urandom));
    end
    idle(LAT + 1);

    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'hABCD);
    drive(1'b1, 1'b1, 1'b0, 16'h0050, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0051, '0);
    pulse_reset();
    random_clear_phase();
    drive(1'b1, 1'b1, 1'b0, 16'h0020, '0);
    idle(LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
